// File: rtl/m_dm_store_pkg.sv
// Shared data-memory definitions: access-width encodings and address map bounds.
// The load extender imports the same encodings.
package m_dm_store_pkg;

  typedef enum logic [1:0] {
    dmWord = 2'b00,
    dmByte = 2'b01,
    dmHalf = 2'b10,
    dmRsvd = 2'b11
  } dm_op_e;

  localparam int unsigned DmWords = 3072;

  localparam logic [31:0] DmHi      = 32'h0000_2FFF;
  localparam logic [31:0] Tmr0Lo    = 32'h0000_7F00;
  localparam logic [31:0] Tmr0CntLo = 32'h0000_7F08;
  localparam logic [31:0] Tmr0Hi    = 32'h0000_7F0B;
  localparam logic [31:0] Tmr1Lo    = 32'h0000_7F10;
  localparam logic [31:0] Tmr1CntLo = 32'h0000_7F18;
  localparam logic [31:0] Tmr1Hi    = 32'h0000_7F1B;
  localparam logic [31:0] IgLo      = 32'h0000_7F20;
  localparam logic [31:0] IgHi      = 32'h0000_7F23;

  function automatic logic in_range(input logic [31:0] a, input logic [31:0] lo,
                                    input logic [31:0] hi);
    return (a >= lo) && (a <= hi);
  endfunction

endpackage

// File: rtl/m_dmin.sv
// Store-side decode: byte enables, lane replication of store data and the
// store address exception.
module m_dmin
  import m_dm_store_pkg::*;
(
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [1:0]  op_i,
  input  logic        is_store_i,
  input  logic        is_addrov_i,
  output logic [3:0]  byteen_o,
  output logic [31:0] wdata_rep_o,
  output logic        in_dm_o,
  output logic        ades_o
);

  logic in_tmr, in_ig, misaligned, out_of_range, timer_subword, timer_count;

  // Width decode, alignment and address-map classification.
  always_comb begin
    byteen_o    = 4'b0000;
    wdata_rep_o = wdata_i;
    misaligned  = 1'b0;
    unique case (dm_op_e'(op_i))
      dmWord: begin
        byteen_o   = 4'b1111;
        misaligned = (addr_i[1:0] != 2'b00);
      end
      dmHalf: begin
        byteen_o    = addr_i[1] ? 4'b1100 : 4'b0011;
        wdata_rep_o = {2{wdata_i[15:0]}};
        misaligned  = addr_i[0];
      end
      dmByte: begin
        byteen_o    = 4'b0001 << addr_i[1:0];
        wdata_rep_o = {4{wdata_i[7:0]}};
      end
      default: begin
        byteen_o = 4'b0000;
      end
    endcase

    in_dm_o       = (addr_i <= DmHi);
    in_tmr        = in_range(addr_i, Tmr0Lo, Tmr0Hi) | in_range(addr_i, Tmr1Lo, Tmr1Hi);
    in_ig         = in_range(addr_i, IgLo, IgHi);
    out_of_range  = ~(in_dm_o | in_tmr | in_ig);
    // Timers only accept full-word stores, and their count registers are read-only.
    timer_subword = in_tmr & (op_i != dmWord);
    timer_count   = in_range(addr_i, Tmr0CntLo, Tmr0Hi) | in_range(addr_i, Tmr1CntLo, Tmr1Hi);
    ades_o        = is_store_i & (misaligned | out_of_range | timer_subword | timer_count |
                                  is_addrov_i);
  end

endmodule

// File: rtl/m_dm_store.sv
// M-stage data memory: 3072-word array with byte-lane writes, commit trace
// and a count of committed writes.
module m_dm_store
  import m_dm_store_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] writeData,
  input  logic [1:0]  CU_DM_op,
  input  logic        is_store,
  input  logic        is_addrOv,
  input  logic        req_flush,
  input  logic [31:0] M_PC,
  output logic [31:0] readData,
  output logic        M_is_AdES,
  output logic        trace_we,
  output logic [31:0] trace_pc,
  output logic [31:0] trace_addr,
  output logic [31:0] trace_data,
  output logic [31:0] store_cnt
);

  logic [31:0] mem_q [DmWords];
  logic [3:0]  byteen;
  logic [31:0] wdata_rep, old_word, merged_word;
  logic [11:0] idx;
  logic        in_dm, ades, commit;

  logic        trace_we_q, trace_we_d;
  logic [31:0] trace_pc_q, trace_pc_d, trace_addr_q, trace_addr_d;
  logic [31:0] trace_data_q, trace_data_d, store_cnt_q, store_cnt_d;

  m_dmin u_dmin (
    .addr_i      (addr),
    .wdata_i     (writeData),
    .op_i        (CU_DM_op),
    .is_store_i  (is_store),
    .is_addrov_i (is_addrOv),
    .byteen_o    (byteen),
    .wdata_rep_o (wdata_rep),
    .in_dm_o     (in_dm),
    .ades_o      (ades)
  );

  assign idx = addr[13:2];

  // Read path, lane merge, commit decision and next-state for trace/counter.
  always_comb begin
    old_word = '0;
    if (in_dm) old_word = mem_q[idx];
    for (int i = 0; i < 4; i++) begin
      merged_word[8*i +: 8] = byteen[i] ? wdata_rep[8*i +: 8] : old_word[8*i +: 8];
    end
    commit       = is_store & ~ades & ~req_flush & in_dm & (byteen != 4'b0000);
    readData     = (in_dm & ~reset) ? old_word : 32'h0;
    trace_we_d   = commit;
    trace_pc_d   = commit ? M_PC : trace_pc_q;
    trace_addr_d = commit ? {addr[31:2], 2'b00} : trace_addr_q;
    trace_data_d = commit ? merged_word : trace_data_q;
    store_cnt_d  = store_cnt_q + 32'd1;
  end

  // Memory array; reset clears every word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DmWords; i++) mem_q[i] <= '0;
    end else if (commit) begin
      mem_q[idx] <= merged_word;
    end
  end

  // Trace registers and commit counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      trace_we_q   <= 1'b0;
      trace_pc_q   <= '0;
      trace_addr_q <= '0;
      trace_data_q <= '0;
      store_cnt_q  <= '0;
    end else begin
      trace_we_q   <= trace_we_d;
      trace_pc_q   <= trace_pc_d;
      trace_addr_q <= trace_addr_d;
      trace_data_q <= trace_data_d;
      if (commit) store_cnt_q <= store_cnt_d;
    end
  end

  assign M_is_AdES  = ades;
  assign trace_we   = trace_we_q;
  assign trace_pc   = trace_pc_q;
  assign trace_addr = trace_addr_q;
  assign trace_data = trace_data_q;
  assign store_cnt  = store_cnt_q;

endmodule

// File: tb/tb_m_dm_store.sv
// Bench for m_dm_store: behavioural memory model checked every cycle, plus
// directed literal expectations and randomized stores.
module tb_m_dm_store;

  logic        clk, reset;
  logic [31:0] addr, writeData, M_PC;
  logic [1:0]  CU_DM_op;
  logic        is_store, is_addrOv, req_flush;
  logic [31:0] readData, trace_pc, trace_addr, trace_data, store_cnt;
  logic        M_is_AdES, trace_we;

  m_dm_store dut (
    .clk        (clk),
    .reset      (reset),
    .addr       (addr),
    .writeData  (writeData),
    .CU_DM_op   (CU_DM_op),
    .is_store   (is_store),
    .is_addrOv  (is_addrOv),
    .req_flush  (req_flush),
    .M_PC       (M_PC),
    .readData   (readData),
    .M_is_AdES  (M_is_AdES),
    .trace_we   (trace_we),
    .trace_pc   (trace_pc),
    .trace_addr (trace_addr),
    .trace_data (trace_data),
    .store_cnt  (store_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state
  logic [31:0] m_mem [3072];
  logic [31:0] m_cnt, m_tpc, m_taddr, m_tdata;
  logic        m_twe;
  logic        p_commit;
  logic [31:0] p_word, p_addr, p_pc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int unsigned op_size(input logic [1:0] op);
    case (op)
      2'b00:   return 4;
      2'b01:   return 1;
      2'b10:   return 2;
      default: return 0;
    endcase
  endfunction

  function automatic logic in_win(input logic [31:0] a, input int unsigned lo,
                                  input int unsigned hi);
    return (a >= lo) && (a <= hi);
  endfunction

  function automatic logic mdl_ades(input logic [31:0] a, input logic [1:0] op,
                                    input logic st, input logic ov);
    int unsigned sz;
    logic mis, tmr, ok, cnt;
    sz  = op_size(op);
    mis = (sz == 4 && a % 4 != 0) || (sz == 2 && a % 2 != 0);
    tmr = in_win(a, 'h7F00, 'h7F0B) || in_win(a, 'h7F10, 'h7F1B);
    ok  = (a < 32'h3000) || tmr || in_win(a, 'h7F20, 'h7F23);
    cnt = in_win(a, 'h7F08, 'h7F0B) || in_win(a, 'h7F18, 'h7F1B);
    return st && (mis || !ok || (tmr && sz != 4) || cnt || ov);
  endfunction

  // Writes the sz-byte datum into the naturally aligned lanes holding address a.
  function automatic logic [31:0] mdl_merge(input logic [31:0] old, input logic [31:0] wd,
                                            input logic [31:0] a, input logic [1:0] op);
    int unsigned sz, first;
    logic [31:0] r;
    r  = old;
    sz = op_size(op);
    if (sz == 0) return r;
    first = ((a % 4) / sz) * sz;
    for (int lane = 0; lane < 4; lane++) begin
      if (lane >= first && lane < first + sz) r[8*lane +: 8] = 8'((wd >> (8 * (lane - first))));
    end
    return r;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 3072; i++) m_mem[i] = '0;
    m_cnt = '0; m_twe = 1'b0; m_tpc = '0; m_taddr = '0; m_tdata = '0;
  endtask

  // Compare process: every negedge check all outputs, then decide the next edge's commit.
  always @(negedge clk) begin
    logic [31:0] exp_rd;
    logic        e_ades;
    if (reset) model_clear();
    exp_rd = (!reset && addr < 32'h3000) ? m_mem[addr[13:2]] : 32'h0;
    e_ades = mdl_ades(addr, CU_DM_op, is_store, is_addrOv);
    chk("readData", readData, exp_rd);
    chk("M_is_AdES", {31'b0, M_is_AdES}, {31'b0, e_ades});
    chk("trace_we", {31'b0, trace_we}, {31'b0, m_twe});
    chk("trace_pc", trace_pc, m_tpc);
    chk("trace_addr", trace_addr, m_taddr);
    chk("trace_data", trace_data, m_tdata);
    chk("store_cnt", store_cnt, m_cnt);
    p_commit = !reset && is_store && !e_ades && !req_flush && addr < 32'h3000 &&
               op_size(CU_DM_op) != 0;
    p_addr   = addr;
    p_pc     = M_PC;
    p_word   = (addr < 32'h3000) ? mdl_merge(m_mem[addr[13:2]], writeData, addr, CU_DM_op) : '0;
  end

  // Model update on the clock edge.
  always @(posedge clk) begin
    m_twe = p_commit;
    if (p_commit) begin
      m_mem[p_addr[13:2]] = p_word;
      m_tpc   = p_pc;
      m_taddr = {p_addr[31:2], 2'b00};
      m_tdata = p_word;
      m_cnt   = m_cnt + 1;
    end
  end

  task automatic cyc(input logic [31:0] a, input logic [31:0] wd, input logic [1:0] op,
                     input logic st, input logic ov, input logic fl, input logic [31:0] pc);
    @(posedge clk);
    #2;
    addr = a; writeData = wd; CU_DM_op = op; is_store = st; is_addrOv = ov;
    req_flush = fl; M_PC = pc;
  endtask

  initial begin
    logic [31:0] a;
    p_commit = 1'b0; p_word = '0; p_addr = '0; p_pc = '0;
    model_clear();
    reset = 1'b1;
    addr = 32'h10; writeData = '0; CU_DM_op = 2'b00; is_store = 1'b0;
    is_addrOv = 1'b0; req_flush = 1'b0; M_PC = '0;
    @(posedge clk); @(posedge clk); #3;
    chk("rst_readData", readData, 32'h0);
    chk("rst_store_cnt", store_cnt, 32'h0);
    @(posedge clk); #2 reset = 1'b0;

    // sw then sb into the same word
    cyc(32'h10, 32'h1234_5678, 2'b00, 1, 0, 0, 32'h0000_3000);
    cyc(32'h11, 32'h0000_00AB, 2'b01, 1, 0, 0, 32'h0000_3004);
    cyc(32'h10, 32'h0, 2'b00, 0, 0, 0, 32'h0000_3008);
    #1;
    chk("sb_merge_read", readData, 32'h1234_AB78);
    chk("sb_merge_cnt", store_cnt, 32'd2);
    chk("sb_merge_trace", trace_data, 32'h1234_AB78);
    chk("sb_trace_addr", trace_addr, 32'h10);

    // exception cases
    cyc(32'h3, 32'h1111, 2'b10, 1, 0, 0, 32'h0000_300C);
    #1 chk("sh_misaligned_ades", {31'b0, M_is_AdES}, 32'd1);
    cyc(32'h7F08, 32'h2222, 2'b00, 1, 0, 0, 32'h0000_3010);
    #1 chk("sw_tmr_count_ades", {31'b0, M_is_AdES}, 32'd1);
    chk("sh_no_trace", {31'b0, trace_we}, 32'd0);
    cyc(32'h7F04, 32'hDEAD_BEEF, 2'b00, 1, 0, 0, 32'h0000_3014);
    #1 chk("sw_tmr_ok", {31'b0, M_is_AdES}, 32'd0);
    cyc(32'h10, 32'h0, 2'b00, 0, 0, 0, 32'h0000_3018);
    #1 chk("periph_no_count", store_cnt, 32'd2);
    chk("periph_no_trace", {31'b0, trace_we}, 32'd0);
    chk("periph_dm_same", readData, 32'h1234_AB78);

    // top of DM and just past it
    cyc(32'h2FFC, 32'hFFFF_FFFF, 2'b00, 1, 0, 0, 32'h0000_301C);
    cyc(32'h3000, 32'h5555_5555, 2'b00, 1, 0, 0, 32'h0000_3020);
    #1 chk("sw_3000_ades", {31'b0, M_is_AdES}, 32'd1);
    cyc(32'h2FFC, 32'h0, 2'b00, 0, 0, 0, 32'h0000_3024);
    #1 chk("sw_2ffc_read", readData, 32'hFFFF_FFFF);
    chk("sw_3000_cnt", store_cnt, 32'd3);

    // flush suppresses commit but not the exception
    cyc(32'h20, 32'hCAFE_F00D, 2'b00, 1, 0, 1, 32'h0000_3028);
    #1 chk("flush_no_ades", {31'b0, M_is_AdES}, 32'd0);
    cyc(32'h20, 32'hCAFE_F00D, 2'b00, 1, 0, 0, 32'h0000_3028);
    #1 chk("flush_no_trace", {31'b0, trace_we}, 32'd0);
    chk("flush_no_write", readData, 32'h0);
    cyc(32'h20, 32'h0, 2'b00, 0, 0, 0, 32'h0000_302C);
    #1 chk("unflushed_read", readData, 32'hCAFE_F00D);
    chk("unflushed_pc", trace_pc, 32'h0000_3028);
    cyc(32'h3, 32'h0, 2'b10, 1, 0, 1, 32'h0000_3030);
    #1 chk("flush_keeps_ades", {31'b0, M_is_AdES}, 32'd1);

    // counter wrap
    cyc(32'h40, 32'h0, 2'b00, 0, 0, 0, 32'h0000_3034);
    force dut.store_cnt_q = 32'hFFFF_FFFF;
    m_cnt = 32'hFFFF_FFFF;
    #1 release dut.store_cnt_q;
    cyc(32'h40, 32'h0000_0042, 2'b00, 1, 0, 0, 32'h0000_3038);
    #1 chk("cnt_preload", store_cnt, 32'hFFFF_FFFF);
    cyc(32'h40, 32'h0, 2'b00, 0, 0, 0, 32'h0000_303C);
    #1 chk("cnt_wrap", store_cnt, 32'h0);

    // reset coincident with a commit edge
    cyc(32'h44, 32'h55AA_55AA, 2'b00, 1, 0, 0, 32'h0000_3040);
    @(posedge clk);
    reset = 1'b1;
    #3;
    chk("rst_mid_read", readData, 32'h0);
    chk("rst_mid_we", {31'b0, trace_we}, 32'd0);
    chk("rst_mid_data", trace_data, 32'h0);
    @(posedge clk); #2;
    reset = 1'b0; is_store = 1'b0;
    #1 chk("rst_mid_mem", readData, 32'h0);
    chk("rst_mid_cnt", store_cnt, 32'h0);

    // randomized traffic
    for (int n = 0; n < 800; n++) begin
      case ($urandom_range(0, 9))
        5:       a = 32'h2FC0 + $urandom_range(0, 63);
        6:       a = 32'h7F00 + $urandom_range(0, 39);
        7:       a = 32'h2FFC + $urandom_range(0, 8);
        8:       a = $urandom;
        default: a = $urandom_range(0, 63);
      endcase
      cyc(a, $urandom, 2'($urandom_range(0, 3)), ($urandom_range(0, 9) < 6),
          ($urandom_range(0, 19) == 0), ($urandom_range(0, 9) == 0), $urandom);
      if (n == 400) begin
        #1 reset = 1'b1;
        @(posedge clk); #2 reset = 1'b0;
      end
    end

    cyc(32'h0, 32'h0, 2'b00, 0, 0, 0, 32'h0);
    @(posedge clk); @(negedge clk); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
